// File: rtl/alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_execute_stage
// Purpose  : Single-cycle ALU execute stage with operand-B mux, immediate
//            sign extension and a one-deep registered result/valid output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_execute_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [2:0]            alu_control,
    input  logic                  alu_src,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic [IMM_WIDTH-1:0]  imm,
    output logic [DATA_WIDTH-1:0] sign_imm,
    output logic [DATA_WIDTH-1:0] src_b,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic [DATA_WIDTH-1:0] result_q,
    output logic                  zero_q,
    output logic                  out_valid
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_ANDN = 3'b100;
    localparam logic [2:0] c_OP_ORN  = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_SLT  = 3'b111;

    logic [DATA_WIDTH-1:0] w_sign_imm;
    logic [DATA_WIDTH-1:0] w_src_b;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_lt;
    logic                  w_zero;

    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_valid;

    assign w_sign_imm = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign w_src_b    = alu_src ? w_sign_imm : rd2;
    assign w_lt       = $signed(src_a) < $signed(w_src_b);

    // Unused opcode 011 falls through to the default and yields zero.
    always_comb begin
        w_alu_result = '0;
        case (alu_control)
            c_OP_AND:  w_alu_result = src_a & w_src_b;
            c_OP_OR:   w_alu_result = src_a | w_src_b;
            c_OP_ADD:  w_alu_result = src_a + w_src_b;
            c_OP_ANDN: w_alu_result = src_a & ~w_src_b;
            c_OP_ORN:  w_alu_result = src_a | ~w_src_b;
            c_OP_SUB:  w_alu_result = src_a - w_src_b;
            c_OP_SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            default:   w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_alu_result;
                r_zero   <= w_zero;
            end
        end
    end

    assign sign_imm   = w_sign_imm;
    assign src_b      = w_src_b;
    assign alu_result = w_alu_result;
    assign zero       = w_zero;
    assign result_q   = r_result;
    assign zero_q     = r_zero;
    assign out_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_execute_stage
// Purpose  : Self-checking bench: directed literal cases plus random traffic
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] src_a;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic [31:0] sign_imm;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q;
    logic        exp_zq;
    logic        exp_v;
    logic        live = 1'b0;

    logic [2:0]  op_tab  [5];
    logic [31:0] res_tab [5];

    always #5 clk = ~clk;

    alu_execute_stage #(.DATA_WIDTH(32), .IMM_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .alu_control(alu_control),
        .alu_src    (alu_src),
        .src_a      (src_a),
        .rd2        (rd2),
        .imm        (imm),
        .sign_imm   (sign_imm),
        .src_b      (src_b),
        .alu_result (alu_result),
        .zero       (zero),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .out_valid  (out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [15:0] i);
        return (i >= 16'h8000) ? (32'hFFFF0000 + 32'(i)) : 32'(i);
    endfunction

    function automatic logic [31:0] m_b(input logic s, input logic [31:0] r, input logic [15:0] i);
        return s ? m_ext(i) : r;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic lt;
        lt = (a[31] != b[31]) ? a[31] : (a < b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            3'd7:    return lt ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference for the registered outputs; inputs are stable around posedge.
    always @(posedge clk) begin
        logic [31:0] r;
        r = m_alu(alu_control, src_a, m_b(alu_src, rd2, imm));
        if (reset) begin
            exp_q  = 32'd0;
            exp_zq = 1'b0;
            exp_v  = 1'b0;
            live   = 1'b1;
        end else begin
            exp_v = in_valid;
            if (in_valid) begin
                exp_q  = r;
                exp_zq = (r == 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] eb;
        logic [31:0] er;
        if (live) begin
            eb = m_b(alu_src, rd2, imm);
            er = m_alu(alu_control, src_a, eb);
            chk("sign_imm",   sign_imm,   m_ext(imm));
            chk("src_b",      src_b,      eb);
            chk("alu_result", alu_result, er);
            chk("zero",       {31'd0, zero}, {31'd0, er == 32'd0});
            chk("result_q",   result_q,   exp_q);
            chk("zero_q",     {31'd0, zero_q},    {31'd0, exp_zq});
            chk("out_valid",  {31'd0, out_valid}, {31'd0, exp_v});
        end
    end

    // Advance to posedge+2, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Check registered outputs just after the next edge, return at posedge+2.
    task automatic reg_chk(input string name, input logic [31:0] rq, input logic zq, input logic v);
        @(posedge clk);
        #1;
        chk({name, "_result_q"},  result_q,            rq);
        chk({name, "_zero_q"},    {31'd0, zero_q},     {31'd0, zq});
        chk({name, "_out_valid"}, {31'd0, out_valid},  {31'd0, v});
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] i);
        in_valid    = v;
        alu_control = op;
        alu_src     = s;
        src_a       = a;
        rd2         = b;
        imm         = i;
    endtask

    initial begin
        op_tab[0] = 3'b000; res_tab[0] = 32'hF000F000;
        op_tab[1] = 3'b001; res_tab[1] = 32'hFFF0FFF0;
        op_tab[2] = 3'b100; res_tab[2] = 32'h00F000F0;
        op_tab[3] = 3'b101; res_tab[3] = 32'hF0FFF0FF;
        op_tab[4] = 3'b011; res_tab[4] = 32'h00000000;

        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 16'd0);
        repeat (3) step();
        chk("rst_result_q",  result_q,           32'd0);
        chk("rst_zero_q",    {31'd0, zero_q},    32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        step();

        drive(1'b1, 3'b010, 1'b1, 32'd5, 32'd0, 16'hFFFF);
        #1;
        chk("add_imm_sign_imm", sign_imm,          32'hFFFFFFFF);
        chk("add_imm_result",   alu_result,        32'd4);
        chk("add_imm_zero",     {31'd0, zero},     32'd0);
        reg_chk("add_imm", 32'd4, 1'b0, 1'b1);

        drive(1'b1, 3'b110, 1'b0, 32'd7, 32'd7, 16'h1234);
        #1;
        chk("sub_eq_result", alu_result,    32'd0);
        chk("sub_eq_zero",   {31'd0, zero}, 32'd1);
        reg_chk("sub_eq", 32'd0, 1'b1, 1'b1);

        drive(1'b1, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 16'd0);
        #1;
        chk("slt_neg_lt_pos", alu_result, 32'd1);
        drive(1'b1, 3'b111, 1'b0, 32'd1, 32'hFFFFFFFF, 16'd0);
        #1;
        chk("slt_pos_lt_neg", alu_result, 32'd0);
        step();

        drive(1'b1, 3'b010, 1'b1, 32'h7FFFFFFF, 32'd0, 16'h0001);
        #1;
        chk("ovf_sign_imm", sign_imm,   32'd1);
        chk("ovf_result",   alu_result, 32'h80000000);
        step();

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, op_tab[k], 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 16'd0);
            #1;
            chk("logic_op_result", alu_result, res_tab[k]);
            chk("logic_op_zero", {31'd0, zero}, {31'd0, res_tab[k] == 32'd0});
            step();
        end

        // Load a result, then reset with in_valid high must discard it.
        drive(1'b1, 3'b001, 1'b0, 32'h00001234, 32'h00005600, 16'd0);
        reg_chk("load", 32'h00005634, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b1, 3'b010, 1'b0, 32'd9, 32'd9, 16'd0);
        #1;
        chk("comb_in_reset", alu_result, 32'd18);
        #1;
        reg_chk("rst_mid", 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b0, 3'b010, 1'b0, 32'd3, 32'd4, 16'd0);
        reg_chk("post_rst_hold1", 32'd0, 1'b0, 1'b0);
        reg_chk("post_rst_hold2", 32'd0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? a : $urandom();
            reset = ($urandom_range(0, 40) == 0);
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), a, b, 16'($urandom()));
            step();
        end

        reset = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_execute_stage.md
ALU_EXECUTE_STAGE -- requirements
Module: alu_execute_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width (only 32 required).
REQ-002 SHALL have parameter IMM_WIDTH, default 16, immediate field width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands/controls valid this cycle.
REQ-006 SHALL have port alu_control  input  3  operation select.
REQ-007 SHALL have port alu_src  input  1  0: SrcB = rd2; 1: SrcB = sign_imm.
REQ-008 SHALL have port src_a  input  32  operand A (register read port 1).
REQ-009 SHALL have port rd2  input  32  register read port 2.
REQ-010 SHALL have port imm  input  16  instruction bits [15:0].
REQ-011 SHALL have port sign_imm  output  32  sign-extended imm, combinational.
REQ-012 SHALL have port src_b  output  32  selected operand B, combinational.
REQ-013 SHALL have port alu_result  output  32  combinational ALU result.
REQ-014 SHALL have port zero  output  1  combinational, 1 when alu_result == 0.
REQ-015 SHALL have port result_q  output  32  registered alu_result.
REQ-016 SHALL have port zero_q  output  1  registered zero.
REQ-017 SHALL have port out_valid  output  1  result_q/zero_q hold a fresh result.

Function
REQ-018 sign_imm SHALL equal {16 copies of imm[15], imm}.
REQ-019 src_b SHALL equal rd2 when alu_src=0, sign_imm when alu_src=1.
REQ-020 alu_control 000 SHALL give src_a AND src_b.
REQ-021 alu_control 001 SHALL give src_a OR src_b.
REQ-022 alu_control 010 SHALL give src_a + src_b, modulo 2^32, no overflow flag.
REQ-023 alu_control 100 SHALL give src_a AND NOT src_b; 101 SHALL give src_a OR NOT src_b.
REQ-024 alu_control 110 SHALL give src_a - src_b, modulo 2^32.
REQ-025 alu_control 111 SHALL give 32'd1 if src_a < src_b as signed two's complement, else 32'd0.
REQ-026 alu_control 011 (unused) SHALL give 32'd0 (zero therefore 1).
REQ-027 sign_imm, src_b, alu_result, zero SHALL be purely combinational, independent of clk, reset, in_valid.
REQ-028 On a rising edge with in_valid=1 and reset=0, result_q/zero_q SHALL capture alu_result/zero (latency 1 cycle).
REQ-029 On a rising edge with in_valid=0 and reset=0, result_q/zero_q SHALL hold their values.
REQ-030 out_valid SHALL equal in_valid of the previous cycle (registered), 0 after reset.
REQ-031 Back-to-back in_valid=1 SHALL yield one registered result per cycle, no bubbles.

Reset
REQ-032 reset=1 at a rising edge SHALL set result_q=0, zero_q=0, out_valid=0, overriding in_valid.
REQ-033 Reset mid-operation SHALL discard the in-flight result; first post-reset capture requires a new in_valid.
REQ-034 Combinational outputs SHALL remain functional during reset.

Verification
REQ-035 src_a=5, imm=16'hFFFF, alu_src=1, alu_control=010, in_valid=1 -> sign_imm=32'hFFFFFFFF, alu_result=4, zero=0; next edge result_q=4, out_valid=1.
REQ-036 src_a=rd2=32'd7, alu_src=0, alu_control=110 -> alu_result=0, zero=1; next edge zero_q=1.
REQ-037 src_a=32'hFFFFFFFF, rd2=1, alu_src=0, alu_control=111 -> alu_result=1; with src_a=1, rd2=32'hFFFFFFFF -> 0.
REQ-038 src_a=32'h7FFFFFFF, imm=16'h0001, alu_src=1, alu_control=010 -> sign_imm=1, alu_result=32'h80000000.
REQ-039 src_a=32'hF0F0F0F0, rd2=32'hFF00FF00, alu_control 000/001/100/101/011 -> F000F000 / FFF0FFF0 / 00F000F0 / F0FFF0FF / 00000000 (zero=1).
REQ-040 Load result, then reset=1 with in_valid=1 for one edge -> result_q=0, zero_q=0, out_valid=0; then in_valid=0 -> values hold at 0.
